// File: rtl/riscv_id_ex_skid_stage_pkg.sv
// Shared widths, state encoding and helpers for the ID/EX elastic stage.
// XLEN and register-index width follow the core configuration.
package riscv_id_ex_skid_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_IDX_W  = 5;
    localparam int CTRL_W_DEF = 16;

    // Occupancy of the two-entry buffer: main only, or main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_t;

    // Writes to x0 never reach the register file, so drop them at capture.
    function automatic logic qualify_we(input logic we, input logic [REG_IDX_W-1:0] rd);
        return we & (rd != '0);
    endfunction

endpackage

// File: rtl/riscv_pipe_slot.sv
// Single payload register with load enable and asynchronous reset value.
// Used for both the main (head) and the skid entries of the ID/EX stage.
module riscv_pipe_slot #(
    parameter int            W    = 1,
    parameter logic [W-1:0]  INIT = '0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= INIT;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/riscv_id_ex_skid_stage.sv
// Decode-to-execute elastic stage: main + skid buffer with registered o_ready,
// synchronous flush for redirects and a saturating back-pressure counter.
module riscv_id_ex_skid_stage
    import riscv_id_ex_skid_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] REGISTER_INIT = '0,
    parameter int              CTRL_W        = CTRL_W_DEF,
    parameter int              STALL_CNT_W   = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [XLEN-1:0]        i_pc,
    input  logic [XLEN-1:0]        i_rs1_data,
    input  logic [XLEN-1:0]        i_rs2_data,
    input  logic [XLEN-1:0]        i_imm,
    input  logic [REG_IDX_W-1:0]   i_rd,
    input  logic                   i_rd_we,
    input  logic [CTRL_W-1:0]      i_ctrl,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [XLEN-1:0]        o_pc,
    output logic [XLEN-1:0]        o_rs1_data,
    output logic [XLEN-1:0]        o_rs2_data,
    output logic [XLEN-1:0]        o_imm,
    output logic [REG_IDX_W-1:0]   o_rd,
    output logic                   o_rd_we,
    output logic [CTRL_W-1:0]      o_ctrl,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    localparam int PAY_W = 4 * XLEN + REG_IDX_W + 1 + CTRL_W;

    localparam logic [PAY_W-1:0] PAY_INIT = {
        REGISTER_INIT, REGISTER_INIT, REGISTER_INIT, REGISTER_INIT,
        REGISTER_INIT[REG_IDX_W-1:0],
        qualify_we(REGISTER_INIT[0], REGISTER_INIT[REG_IDX_W-1:0]),
        CTRL_W'(REGISTER_INIT)
    };

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == '1) ? v : v + STALL_CNT_W'(1);
    endfunction

    skid_state_t      state_q;
    skid_state_t      state_d;
    logic             accept;
    logic             xfer;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;
    logic [PAY_W-1:0] in_pay_p0;
    logic [PAY_W-1:0] main_d_p0;
    logic [PAY_W-1:0] main_pay_p1;
    logic [PAY_W-1:0] skid_pay_p1;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Stage input: pack the decoded operands, qualifying rd_we on the way in.
    assign in_pay_p0 = {i_pc, i_rs1_data, i_rs2_data, i_imm, i_rd,
                        qualify_we(i_rd_we, i_rd), i_ctrl};

    assign o_valid = (state_q != ST_EMPTY);
    assign o_ready = (state_q != ST_SKID);
    assign accept  = i_valid & o_ready;
    assign xfer    = o_valid & i_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (i_flush) begin
            // Payload may go stale here; it is ignored while o_valid is low.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_FULL;
                        load_main = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && xfer) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_SKID;
                        load_skid = 1'b1;
                    end else if (xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (xfer) begin
                        state_d        = ST_FULL;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign main_d_p0 = main_from_skid ? skid_pay_p1 : in_pay_p0;

    // Stage output: the main slot is always the head entry driven downstream.
    riscv_pipe_slot #(
        .W    (PAY_W),
        .INIT (PAY_INIT)
    ) u_main_slot (
        .clk  (i_clk),
        .rstn (i_rstn),
        .load (load_main),
        .d    (main_d_p0),
        .q    (main_pay_p1)
    );

    riscv_pipe_slot #(
        .W    (PAY_W),
        .INIT (PAY_INIT)
    ) u_skid_slot (
        .clk  (i_clk),
        .rstn (i_rstn),
        .load (load_skid),
        .d    (in_pay_p0),
        .q    (skid_pay_p1)
    );

    assign {o_pc, o_rs1_data, o_rs2_data, o_imm, o_rd, o_rd_we, o_ctrl} = main_pay_p1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stall_cnt_q <= '0;
        end else if (o_valid && !i_ready) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_riscv_id_ex_skid_stage.sv
// Randomized and directed bench for the ID/EX skid stage, checked against a
// queue-based model of a two-deep FIFO with flush and saturating stall count.
module tb_riscv_id_ex_skid_stage;

    localparam int XLEN    = 32;
    localparam int CTRL_W  = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
        logic [15:0] ctrl;
    } ent_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              flush = 1'b0;
    logic              valid = 1'b0;
    logic              o_ready;
    logic [XLEN-1:0]   pc = '0, rs1 = '0, rs2 = '0, imm = '0;
    logic [4:0]        rd = '0;
    logic              rd_we = 1'b0;
    logic [CTRL_W-1:0] ctrl = '0;
    logic              o_valid;
    logic              rdy = 1'b0;
    logic [XLEN-1:0]   o_pc, o_rs1, o_rs2, o_imm;
    logic [4:0]        o_rd;
    logic              o_rd_we;
    logic [CTRL_W-1:0] o_ctrl;
    logic [CNT_W-1:0]  o_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t q[$];
    int   m_cnt = 0;

    riscv_id_ex_skid_stage #(
        .REGISTER_INIT ('0),
        .CTRL_W        (CTRL_W),
        .STALL_CNT_W   (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_flush     (flush),
        .i_valid     (valid),
        .o_ready     (o_ready),
        .i_pc        (pc),
        .i_rs1_data  (rs1),
        .i_rs2_data  (rs2),
        .i_imm       (imm),
        .i_rd        (rd),
        .i_rd_we     (rd_we),
        .i_ctrl      (ctrl),
        .o_valid     (o_valid),
        .i_ready     (rdy),
        .o_pc        (o_pc),
        .o_rs1_data  (o_rs1),
        .o_rs2_data  (o_rs2),
        .o_imm       (o_imm),
        .o_rd        (o_rd),
        .o_rd_we     (o_rd_we),
        .o_ctrl      (o_ctrl),
        .o_stall_cnt (o_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic r, input logic f);
        valid = v;
        pc    = p;
        rdy   = r;
        flush = f;
        rs1   = $urandom;
        rs2   = $urandom;
        imm   = $urandom;
        rd    = 5'($urandom_range(0, 31));
        rd_we = 1'($urandom_range(0, 1));
        ctrl  = 16'($urandom);
    endtask

    task automatic compare_all();
        check("valid", 64'(o_valid), 64'(q.size() > 0));
        check("ready", 64'(o_ready), 64'(q.size() < 2));
        check("stall_cnt", 64'(o_cnt), 64'(m_cnt));
        if (q.size() > 0) begin
            check("pc", 64'(o_pc), 64'(q[0].pc));
            check("rs1", 64'(o_rs1), 64'(q[0].rs1));
            check("rs2", 64'(o_rs2), 64'(q[0].rs2));
            check("imm", 64'(o_imm), 64'(q[0].imm));
            check("rd", 64'(o_rd), 64'(q[0].rd));
            check("rd_we", 64'(o_rd_we), 64'(q[0].we));
            check("ctrl", 64'(o_ctrl), 64'(q[0].ctrl));
        end
    endtask

    // One clock: advance the model on the values presented at the edge, then compare.
    task automatic step();
        ent_t e;
        bit   acc;
        bit   outx;
        @(posedge clk);
        e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
        e.rd = rd; e.we = rd_we && (rd != 5'd0); e.ctrl = ctrl;
        acc  = valid && (q.size() < 2);
        outx = (q.size() > 0) && rdy;
        if (q.size() > 0 && !rdy && m_cnt < CNT_MAX) m_cnt++;
        if (flush) begin
            q.delete();
        end else begin
            if (outx) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
        compare_all();
    endtask

    initial begin
        // Reset and idle.
        #2 rstn = 1'b0;
        #1;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_pc", 64'(o_pc), 64'd0);
        check("rst_cnt", 64'(o_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("idle_pc", 64'(o_pc), 64'd0);

        // Streaming with i_ready high.
        drive(1'b1, 32'h100, 1'b1, 1'b0); step();
        check("stream_pc0", 64'(o_pc), 64'h100);
        drive(1'b1, 32'h104, 1'b1, 1'b0); step();
        check("stream_pc1", 64'(o_pc), 64'h104);
        drive(1'b1, 32'h108, 1'b1, 1'b0); step();
        check("stream_pc2", 64'(o_pc), 64'h108);
        drive(1'b0, 32'h0, 1'b1, 1'b0); step();

        // Back-pressure into the skid slot, then drain.
        drive(1'b1, 32'h200, 1'b0, 1'b0); step();
        drive(1'b1, 32'h204, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("bp_hold_pc", 64'(o_pc), 64'h200);
        check("bp_ready_low", 64'(o_ready), 64'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0); step();
        check("bp_drain_pc", 64'(o_pc), 64'h204);
        step();
        step();

        // rd = x0 qualification.
        drive(1'b1, 32'h180, 1'b1, 1'b0); rd = 5'd0; rd_we = 1'b1; step();
        check("x0_we", 64'(o_rd_we), 64'd0);
        drive(1'b1, 32'h184, 1'b1, 1'b0); rd = 5'd5; rd_we = 1'b1; step();
        check("x5_we", 64'(o_rd_we), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0); step();

        // Flush in SKID state with a same-cycle input.
        drive(1'b1, 32'h2f0, 1'b0, 1'b0); step();
        drive(1'b1, 32'h2f4, 1'b0, 1'b0); step();
        drive(1'b1, 32'h300, 1'b0, 1'b1); step();
        check("flush_valid", 64'(o_valid), 64'd0);
        check("flush_ready", 64'(o_ready), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step();

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 39) == 0));
            if ($urandom_range(0, 7) == 0) rd = 5'd0;
            step();
        end

        // Asynchronous reset mid-stream, away from any clock edge.
        drive(1'b1, 32'h400, 1'b0, 1'b0); step();
        drive(1'b1, 32'h404, 1'b0, 1'b0); step();
        #2 rstn = 1'b0;
        valid = 1'b0;
        #1;
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_ready", 64'(o_ready), 64'd1);
        check("arst_cnt", 64'(o_cnt), 64'd0);
        check("arst_pc", 64'(o_pc), 64'd0);
        q.delete();
        m_cnt = 0;
        @(negedge clk);
        rstn = 1'b1;

        // Counter saturation.
        drive(1'b1, 32'h500, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        check("sat_cnt", 64'(o_cnt), 64'd15);
        check("sat_pc", 64'(o_pc), 64'h500);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("sat_kept", 64'(o_cnt), 64'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_id_ex_skid_stage.md
Name: riscv_id_ex_skid_stage

Overview:
Elastic pipeline stage between decode (operand read) and execute in the RISC-V core.
- Captures decoded operands (PC, rs1/rs2 data, immediate, rd, control) with a valid/ready handshake.
- Holds a 2-entry buffer (main + skid), so o_ready is a registered signal and never depends combinationally on i_ready.
- Supports synchronous flush for branch/trap redirect and keeps a saturating back-pressure stall counter.

Parameters:
REGISTER_INIT, 0, reset value of all payload output registers
CTRL_W, 16, width of opaque execute-control bundle
STALL_CNT_W, 32, width of stall counter

Ports:
i_clk  input  1  clock
i_rstn  input  1  reset, asynchronous, active-low
i_flush  input  1  synchronous flush; discards all held and incoming entries
i_valid  input  1  upstream entry valid
o_ready  output  1  stage can accept an entry this cycle
i_pc  input  XLEN  instruction PC
i_rs1_data  input  XLEN  rs1 operand
i_rs2_data  input  XLEN  rs2 operand
i_imm  input  XLEN  sign-extended immediate
i_rd  input  5  destination register index
i_rd_we  input  1  destination write enable
i_ctrl  input  CTRL_W  execute control bundle
o_valid  output  1  downstream entry valid
i_ready  input  1  execute accepts entry
o_pc, o_rs1_data, o_rs2_data, o_imm  output  XLEN each  head-entry payload
o_rd  output  5  head-entry rd
o_rd_we  output  1  head-entry write enable, qualified
o_ctrl  output  CTRL_W  head-entry control
o_stall_cnt  output  STALL_CNT_W  cycles with o_valid=1 and i_ready=0

Behaviour:
Reset (i_rstn low, asynchronous):
- All payload registers and o_stall_cnt go to REGISTER_INIT / 0.
- o_valid=0, skid_valid=0, o_ready=1.

Handshake:
- Accept = i_valid & o_ready.
- Transfer out = o_valid & i_ready.
- o_ready = !skid_valid (registered).
- Payload outputs are always driven from the main register.

States (derived from main_valid/skid_valid):
- EMPTY: accept -> FULL; main loads input. No accept -> stay.
- FULL:
  - accept & out -> FULL; main loads input.
  - accept & !out -> SKID; skid loads input, main unchanged.
  - !accept & out -> EMPTY.
  - neither -> stay.
- SKID: o_ready=0. out -> FULL; main loads skid and skid_valid clears. !out -> stay, all payload stable.

Latency and ordering:
- Latency is 1 cycle from accept to o_valid when the stage is empty.
- Throughput is 1/cycle when i_ready is held high.
- Order is strictly FIFO; no entry is dropped or duplicated except on flush.

Flush:
- i_flush=1 overrides everything; the next state is EMPTY (o_valid=0, skid_valid=0, o_ready=1).
- An input presented in the same cycle is discarded.
- Payload registers may hold stale data but are don't-care while o_valid=0.
- o_stall_cnt is not cleared by flush.

Write-enable qualification:
- o_rd_we = stored rd_we & (stored rd != 0). Writes to x0 are suppressed at capture.

Stall counter:
- Increments by 1 each cycle with o_valid & !i_ready.
- Saturates at all-ones and never wraps.
- Cleared only by reset.

Payload stability:
- While o_valid=1 and i_ready=0, all o_* payload outputs are held constant (AXI-style).

Simultaneous flush and output transfer: the transfer counts and the flush still empties the stage.

Decomposition:
- riscv_configs.v: XLEN, REG_IDX_W (5), and a CTRL_W default define.
- One sub-module, riscv_pipe_slot: payload register with load enable and async reset to REGISTER_INIT. Instantiated twice (main, skid).
- The FSM, handshake logic and counter stay in the top.

Test Plan:
- Reset then idle: o_valid=0, o_ready=1, o_pc=0, o_stall_cnt=0; no change over 10 cycles with i_valid=0.
- Streaming with i_ready=1: send PCs 0x100, 0x104, 0x108 back-to-back -> o_valid from cycle+1, o_pc 0x100/0x104/0x108 on consecutive cycles, o_ready stays 1.
- Back-pressure: i_ready=0 with 0x200 then 0x204 sent -> o_ready=0 after the second accept, o_pc holds 0x200, o_stall_cnt counts; raise i_ready -> 0x200 then 0x204 out in order, o_ready returns to 1 one cycle after the skid drains.
- rd=x0 qualification: send i_rd=0 with i_rd_we=1 -> o_rd_we=0; send i_rd=5 with i_rd_we=1 -> o_rd_we=1.
- Flush in SKID state with i_valid=1 (PC 0x300) in the same cycle -> next cycle o_valid=0, o_ready=1; 0x300 never appears; o_stall_cnt retained.
- Counter saturation (STALL_CNT_W=4): hold o_valid=1 and i_ready=0 for 20 cycles -> o_stall_cnt=15, no wrap. Async reset asserted mid-stream -> all outputs reset immediately without waiting for a clock edge.
